// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg: shared state type, default fill pattern and sizing helper
// for the fifo_width_packer block.
package fifo_pack_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STOP  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } pack_state_t;

  localparam logic [31:0] DEFAULT_PAD = 32'hF0F0_F0F0;

  // Bits needed to index RATIO lanes; never less than one bit.
  function automatic int lane_idx_w(input int ratio);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < ratio) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_pack_gate.sv
// fifo_pack_gate: registered run-control flags for the width packer.
//   ddr_ready : set by ddr_start, cleared by ddr_stop (start has priority)
//   hold      : set by dst_afull, cleared by dst_empty (afull has priority)
//   last_q    : last_write delayed by one clock
module fifo_pack_gate (
  input  logic digiclk_i,
  input  logic resetn_i,
  input  logic ddr_start,
  input  logic ddr_stop,
  input  logic dst_afull,
  input  logic dst_empty,
  input  logic last_write,
  output logic ddr_ready,
  output logic hold,
  output logic last_q
);

  // Flag registers with their set/clear priorities.
  always_ff @(posedge digiclk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      ddr_ready <= 1'b0;
      hold      <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      if (ddr_start)      ddr_ready <= 1'b1;
      else if (ddr_stop)  ddr_ready <= 1'b0;

      if (dst_afull)      hold <= 1'b1;
      else if (dst_empty) hold <= 1'b0;

      last_q <= last_write;
    end
  end

endmodule

// File: rtl/fifo_width_packer.sv
// fifo_width_packer: packs RATIO consecutive IN_W-bit words from a
// 1-cycle-latency source FIFO into one OUT_W-bit destination word.
// Lane 0 (first word read) lands in the LSBs.
// Optional feature macro: PACKER_FLUSH_EN -- when defined, an end-of-run
// flush emits a partial group padded with PAD; otherwise the partial group
// is kept and completed by the next run.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for DDR ready
// RUN   | reading source and packing
// STOP  | reads stopped, letting the last in-flight word land
// FLUSH | one cycle; optionally emits the padded partial group
// DONE  | end of run, waiting for last_write to drop
module fifo_width_packer
  import fifo_pack_pkg::*;
#(
  parameter int              IN_W  = 32,
  parameter int              RATIO = 2,
  parameter int              CNT_W = 17,
  parameter logic [IN_W-1:0] PAD   = IN_W'(DEFAULT_PAD)
) (
  input  logic                  digiclk_i,
  input  logic                  resetn_i,
  input  logic [CNT_W-1:0]      src_rdcnt,
  input  logic [IN_W-1:0]       src_data,
  output logic                  src_re,
  input  logic                  dst_afull,
  input  logic                  dst_empty,
  input  logic                  dst_full,
  output logic                  dst_we,
  output logic [IN_W*RATIO-1:0] dst_data,
  input  logic                  ddr_start,
  input  logic                  ddr_stop,
  input  logic                  last_write,
  output logic [31:0]           words_out,
  output logic                  ovf_err
);

  localparam int OUT_W  = IN_W * RATIO;
  localparam int LIDX_W = lane_idx_w(RATIO);
  localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(RATIO - 1);

  pack_state_t                 state;
  logic                        ddr_ready;
  logic                        hold;
  logic                        last_q;
  logic                        re_d;
  logic                        gate;
  logic                        have_word;
  logic [LIDX_W-1:0]           lane_idx;
  logic [RATIO-1:0][IN_W-1:0]  lanes;
  logic [RATIO-1:0][IN_W-1:0]  next_lanes;
  logic [OUT_W-1:0]            packed_word;

  fifo_pack_gate u_gate (
    .digiclk_i  (digiclk_i),
    .resetn_i   (resetn_i),
    .ddr_start  (ddr_start),
    .ddr_stop   (ddr_stop),
    .dst_afull  (dst_afull),
    .dst_empty  (dst_empty),
    .last_write (last_write),
    .ddr_ready  (ddr_ready),
    .hold       (hold),
    .last_q     (last_q)
  );

  // dst_afull is used raw here so the read stops in the same cycle it rises.
  assign gate = ddr_ready & ~hold & ~dst_afull & (state == RUN);

  // With one word left and a read already in flight, that word is spoken for.
  assign have_word = (src_rdcnt >= CNT_W'(2)) |
                     ((src_rdcnt == CNT_W'(1)) & ~re_d);

  assign src_re = gate & have_word;

  // Lane contents including the word arriving this cycle.
  always_comb begin
    next_lanes = lanes;
    if (re_d) next_lanes[lane_idx] = src_data;
  end

  assign packed_word = next_lanes;

  // Lane capture, output word, counters and run-control FSM.
  always_ff @(posedge digiclk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state     <= IDLE;
      re_d      <= 1'b0;
      lane_idx  <= '0;
      lanes     <= {RATIO{PAD}};
      dst_we    <= 1'b0;
      dst_data  <= '0;
      words_out <= '0;
      ovf_err   <= 1'b0;
    end else begin
      re_d    <= src_re;
      dst_we  <= 1'b0;
      ovf_err <= ovf_err | (dst_we & dst_full);

      if (re_d) begin
        if (lane_idx == LAST_LANE) begin
          lane_idx  <= '0;
          lanes     <= {RATIO{PAD}};
          dst_we    <= 1'b1;
          dst_data  <= packed_word;
          words_out <= words_out + 32'd1;
        end else begin
          lane_idx <= lane_idx + 1'b1;
          lanes    <= next_lanes;
        end
      end

      case (state)
        IDLE: begin
          if (ddr_ready) state <= RUN;
        end
        RUN: begin
          if (last_q)          state <= STOP;
          else if (!ddr_ready) state <= IDLE;
        end
        STOP: begin
          state <= FLUSH;
        end
        FLUSH: begin
`ifdef PACKER_FLUSH_EN
          // No read is in flight here, so packed_word is the held lanes
          // with PAD in every lane not yet written.
          if (lane_idx != '0) begin
            lane_idx  <= '0;
            lanes     <= {RATIO{PAD}};
            dst_we    <= 1'b1;
            dst_data  <= packed_word;
            words_out <= words_out + 32'd1;
          end
`endif
          state <= DONE;
        end
        DONE: begin
          if (!last_q) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_width_packer.md
# fifo_width_packer

Parametrised successor to the 32→64-bit DIGIFIFO-to-TEMPFIFO converter. It reads IN_W-bit words from a standard (1-cycle read latency) source FIFO and packs RATIO consecutive words into one OUT_W-bit word written to the DDR-side destination FIFO. It sustains one input word per clock, gates reading on DDR readiness and destination backpressure, and on `last_write` can flush a partial group padded with a fill pattern. It sits between the digitizer FIFO and the DDR write path.

## Interface
- IN_W, 32, source word width
- RATIO, 2, input words per output word (≥2); OUT_W = IN_W*RATIO (localparam)
- CNT_W, 17, width of source read count
- PAD, 32'hF0F0_F0F0, fill pattern for unwritten lanes (IN_W bits)
- digiclk_i  in  1  clock
- resetn_i  in  1  reset; one clock; reset is asynchronous and active-low
- src_rdcnt  in  CNT_W  words available in source FIFO
- src_data  in  IN_W  source read data, valid the cycle after src_re
- src_re  out  1  source read enable
- dst_afull  in  1  destination almost full
- dst_empty  in  1  destination empty
- dst_full  in  1  destination full
- dst_we  out  1  destination write enable
- dst_data  out  OUT_W  packed word; lane 0 = first word read, in LSBs
- ddr_start  in  1  DDR ready pulse
- ddr_stop  in  1  DDR not-ready pulse
- last_write  in  1  end-of-run request (level)
- words_out  out  32  output words written since reset
- ovf_err  out  1  sticky: dst_we asserted while dst_full

## Operation
- Flags, registered: `ddr_ready` set by ddr_start, cleared by ddr_stop, start wins if both. `hold` set by dst_afull, cleared by dst_empty, afull wins if both. `last_q` = last_write delayed one clock.
- gate = ddr_ready & ~hold & ~dst_afull & state==RUN.
- src_re = gate & (src_rdcnt ≥ 2 | (src_rdcnt == 1 & ~re_d)), where re_d = src_re delayed one clock. This rule never over-reads.
- On re_d, src_data goes to lane[lane_idx], and lane_idx advances mod RATIO. When lane RATIO-1 is captured, the next cycle has dst_we=1, dst_data = packed lanes, words_out+1. Unfilled lane registers hold PAD.
- States:
  - IDLE: stays until ddr_ready, then → RUN.
  - RUN: on last_q=1 → STOP; on ddr_ready=0 → IDLE, keeping the partial group.
  - STOP: src_re=0; wait one cycle for the in-flight read → FLUSH.
  - FLUSH: one cycle; if lane_idx≠0 (see Configuration), emit the padded word; → DONE.
  - DONE: src_re=0 until last_q=0 → IDLE.
- words_out wraps at 2^32.
- ovf_err clears only on reset.

## Timing
- Reset values: src_re=0, dst_we=0, dst_data=0, words_out=0, ovf_err=0. Also state=IDLE, lane_idx=0, lanes=PAD.
- src_re to data capture: 1 cycle. Last lane capture to dst_we: 1 cycle. First src_re of a group to its dst_we: RATIO+1 cycles.
- Back-to-back groups give dst_we every RATIO cycles with no bubbles.
- dst_afull drops src_re combinationally in the same cycle. At most 2 more writes can follow (in-flight reads).
- Reset mid-group discards the partial lanes. Reset is asynchronous and active-low.

## Configuration
- PACKER_FLUSH_EN defined: in FLUSH with lane_idx≠0, emit one word with the remaining lanes = PAD, then clear lane_idx to 0.
- Not defined: FLUSH emits nothing. The partial lanes and lane_idx are retained and completed by the next run's reads.

## Structure
- Package fifo_pack_pkg: state enum (IDLE, RUN, STOP, FLUSH, DONE), default PAD constant, helper function for clog2(RATIO).
- One sub-module, fifo_pack_gate: ddr_ready, hold and last_q flag registers with their priority rules.
- Lane registers, lane_idx, FSM and counters live in the top module.

## Test plan
- RATIO=2: source words 0x1,0x2,0x3,0x4 with ready set → dst_data 0x00000002_00000001 then 0x00000004_00000003; words_out=2.
- src_rdcnt=1 held (single word), then a second word arrives → exactly 2 src_re pulses, never on an empty FIFO; one write.
- dst_afull mid-stream → src_re drops in the same cycle; resumes only after dst_empty; no word lost or duplicated.
- RATIO=4, 3 words then last_write, PACKER_FLUSH_EN defined → one write {PAD,w3,w2,w1}. Without the macro → no write; the next word completes the group.
- ddr_start and ddr_stop in the same cycle → ddr_ready=1. Reset asserted mid-group → all outputs 0 and lanes=PAD.
- Force dst_full during dst_we → ovf_err=1 and stays set until reset.
